// File: rtl/spi_crc_accum.sv
// spi_crc_accum: byte-wide CRC accumulator that folds each accepted word into the CRC one nibble per clock.
// Define SPI_CRC_CHECK_EN to add the reference-CRC compare (i_ref_crc / o_crc_err).
module spi_crc_accum #(
    parameter int WPOLY = 9,
    parameter int WDATA = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WPOLY-1:0] i_poly,
    input  logic [WPOLY-2:0] i_init,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [WDATA-1:0] i_data,
    input  logic             i_last,
`ifdef SPI_CRC_CHECK_EN
    input  logic [WPOLY-2:0] i_ref_crc,
    output logic             o_crc_err,
`endif
    output logic             o_ready,
    output logic             o_busy,
    output logic [WPOLY-2:0] o_crc,
    output logic             o_crc_valid
);

    localparam int C    = WPOLY - 1;
    localparam int NNIB = WDATA / 4;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WDATA-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [C-1:0]     crc_q, crc_d;
    logic             ready;
    logic             accept;
    logic [3:0]       nib;

    // The shift is done at full polynomial width so the leading 1 of i_poly cancels the carried-out bit.
    function automatic logic [C-1:0] nibbleStep(input logic [C-1:0] crc, input logic [3:0] n,
                                                input logic [WPOLY-1:0] poly);
        logic [C-1:0]     t;
        logic [WPOLY-1:0] w;
        t = crc;
        t[C-1 -: 4] = t[C-1 -: 4] ^ n;
        for (int k = 0; k < 4; k++) begin
            w = {t, 1'b0};
            if (w[WPOLY-1]) w = w ^ poly;
            t = w[C-1:0];
        end
        return t;
    endfunction

    assign ready  = !i_start &&
                    ((state_q == IDLE) || ((state_q == PROC) && (cnt_q == '0) && !last_q));
    assign accept = i_valid && ready;
    assign nib    = data_q[{cnt_q, 2'b00} +: 4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
        end
    end

    // i_start overrides everything; in the final nibble cycle a new word may be captured back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        crc_d   = crc_q;
        if (i_start) begin
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
            crc_d   = i_init;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_d  = i_data;
                        last_d  = i_last;
                        cnt_d   = CW'(NNIB - 1);
                        state_d = PROC;
                    end
                end
                PROC: begin
                    crc_d = nibbleStep(crc_q, nib, i_poly);
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (accept) begin
                        data_d = i_data;
                        last_d = i_last;
                        cnt_d  = CW'(NNIB - 1);
                    end else if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_ready     = ready;
    assign o_busy      = (state_q == PROC);
    assign o_crc       = crc_q;
    assign o_crc_valid = (state_q == DONE);

`ifdef SPI_CRC_CHECK_EN
    logic [C-1:0] ref_q, ref_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ref_q <= '0;
        else       ref_q <= ref_d;
    end

    always_comb begin
        ref_d = ref_q;
        if (accept && i_last) ref_d = i_ref_crc;
    end

    assign o_crc_err = (state_q == DONE) && (crc_q != ref_q);
`endif

endmodule

// File: tb/tb_spi_crc_accum.sv
// tb_spi_crc_accum: randomized self-checking bench for spi_crc_accum (CRC-8 configuration).
// A bit-serial CRC model in the bench provides every expected CRC value.
module tb_spi_crc_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] poly;
    logic [7:0] init;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;
    logic       busy;
    logic [7:0] crc;
    logic       crcValid;
`ifdef SPI_CRC_CHECK_EN
    logic [7:0] refCrc;
    logic       crcErr;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    spi_crc_accum #(.WPOLY(9), .WDATA(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_poly     (poly),
        .i_init     (init),
        .i_start    (start),
        .i_valid    (valid),
        .i_data     (data),
        .i_last     (last),
`ifdef SPI_CRC_CHECK_EN
        .i_ref_crc  (refCrc),
        .o_crc_err  (crcErr),
`endif
        .o_ready    (ready),
        .o_busy     (busy),
        .o_crc      (crc),
        .o_crc_valid(crcValid)
    );

    // Bit-at-a-time reference: MSB-first, non-reflected, no final XOR.
    function automatic logic [7:0] crcByte(input logic [7:0] seed, input logic [8:0] p, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = seed;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = c << 1;
            if (fb) c = c ^ p[7:0];
        end
        return c;
    endfunction

    task automatic doStart(input logic [8:0] p, input logic [7:0] s);
        poly  = p;
        init  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] d, input logic l);
        int waitCnt = 0;
        valid = 1'b1;
        data  = d;
        last  = l;
        @(negedge clk);
        while (!ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        nCompared++;
        if (ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sendWord_ready_timeout: got %b, want 1", ready);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        data  = 8'($urandom);
        last  = 1'($urandom);
    endtask

    task automatic waitCrcValid(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (crcValid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        nCompared += 4;
        if (ready !== 1'b1)    begin nMismatched++; $display("[TB] FAIL reset_ready: got %b, want 1", ready); end
        if (busy !== 1'b0)     begin nMismatched++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        if (crc !== 8'h00)     begin nMismatched++; $display("[TB] FAIL reset_crc: got %h, want 00", crc); end
        if (crcValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_crc_valid: got %b, want 0", crcValid); end
`ifdef SPI_CRC_CHECK_EN
        nCompared++;
        if (crcErr !== 1'b0)   begin nMismatched++; $display("[TB] FAIL reset_crc_err: got %b, want 0", crcErr); end
`endif
        #13 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_words();
        logic [7:0] din [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
        logic [7:0] dexp[4] = '{8'h07, 8'h89, 8'hF3, 8'h00};
        int lat;
        for (int v = 0; v < 4; v++) begin
            doStart(9'h107, 8'h00);
            sendWord(din[v], 1'b1);
            waitCrcValid(lat);
            nCompared += 4;
            if (lat != 3)        begin nMismatched++; $display("[TB] FAIL single_latency[%0d]: got %0d, want 3", v, lat); end
            if (crc !== dexp[v]) begin nMismatched++; $display("[TB] FAIL single_crc[%0d]: got %h, want %h", v, crc, dexp[v]); end
            if (ready !== 1'b0)  begin nMismatched++; $display("[TB] FAIL done_ready[%0d]: got %b, want 0", v, ready); end
            if (busy !== 1'b0)   begin nMismatched++; $display("[TB] FAIL done_busy[%0d]: got %b, want 0", v, busy); end
            @(posedge clk); #1;
            @(negedge clk);
            nCompared += 2;
            if (crcValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_pulse_width[%0d]: got %b, want 0", v, crcValid); end
            if (crc !== dexp[v])   begin nMismatched++; $display("[TB] FAIL single_crc_hold[%0d]: got %h, want %h", v, crc, dexp[v]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int lat;
        int pulses = 0;
        logic [7:0] model = 8'h00;
        doStart(9'h107, 8'h00);
        for (int cyc = 0; cyc < 18; cyc++) begin
            valid = (idx < 9);
            data  = 8'h31 + 8'(idx);
            last  = (idx == 8);
            @(negedge clk);
            nCompared++;
            if (ready !== ((cyc % 2) == 0)) begin
                nMismatched++;
                $display("[TB] FAIL b2b_ready[cyc %0d]: got %b, want %b", cyc, ready, ((cyc % 2) == 0));
            end
            if (valid && ready) begin
                model = crcByte(model, 9'h107, data);
                idx++;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        nCompared++;
        if (idx != 9) begin nMismatched++; $display("[TB] FAIL b2b_accepts: got %0d, want 9", idx); end
        waitCrcValid(lat);
        nCompared += 3;
        if (lat != 2)      begin nMismatched++; $display("[TB] FAIL b2b_latency: got %0d, want 2", lat); end
        if (crc !== 8'hF4) begin nMismatched++; $display("[TB] FAIL b2b_crc: got %h, want f4", crc); end
        if (crc !== model) begin nMismatched++; $display("[TB] FAIL b2b_crc_model: got %h, want %h", crc, model); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (crcValid === 1'b1) pulses++;
        end
        nCompared++;
        if (pulses != 0) begin nMismatched++; $display("[TB] FAIL b2b_extra_pulses: got %0d, want 0", pulses); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_abort();
        int lat;
        int pulses = 0;
        logic [7:0] want;
        doStart(9'h107, 8'h00);
        sendWord(8'hFF, 1'b1);
        init  = 8'h5A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        nCompared += 4;
        if (crc !== 8'h5A)     begin nMismatched++; $display("[TB] FAIL abort_crc: got %h, want 5a", crc); end
        if (busy !== 1'b0)     begin nMismatched++; $display("[TB] FAIL abort_busy: got %b, want 0", busy); end
        if (ready !== 1'b1)    begin nMismatched++; $display("[TB] FAIL abort_ready: got %b, want 1", ready); end
        if (crcValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_crc_valid: got %b, want 0", crcValid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (crcValid === 1'b1) pulses++;
        end
        nCompared++;
        if (pulses != 0) begin nMismatched++; $display("[TB] FAIL abort_stray_pulse: got %0d, want 0", pulses); end
        @(posedge clk); #1;
        sendWord(8'h00, 1'b1);
        want = crcByte(8'h5A, 9'h107, 8'h00);
        waitCrcValid(lat);
        nCompared += 2;
        if (lat != 3)     begin nMismatched++; $display("[TB] FAIL abort_latency: got %0d, want 3", lat); end
        if (crc !== want) begin nMismatched++; $display("[TB] FAIL abort_reseed_crc: got %h, want %h", crc, want); end
        @(posedge clk); #1;
        init  = 8'h33;
        start = 1'b1;
        valid = 1'b1;
        data  = 8'h11;
        last  = 1'b1;
        @(negedge clk);
        nCompared++;
        if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL start_blocks_ready: got %b, want 0", ready); end
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        nCompared += 2;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL start_word_not_taken: got %b, want 0", busy); end
        if (crc !== 8'h33) begin nMismatched++; $display("[TB] FAIL start_seed: got %h, want 33", crc); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        doStart(9'h107, 8'hA5);
        sendWord(8'h3C, 1'b0);
        #2 rst = 1'b1;
        #1;
        nCompared += 4;
        if (crc !== 8'h00)     begin nMismatched++; $display("[TB] FAIL async_rst_crc: got %h, want 00", crc); end
        if (ready !== 1'b1)    begin nMismatched++; $display("[TB] FAIL async_rst_ready: got %b, want 1", ready); end
        if (busy !== 1'b0)     begin nMismatched++; $display("[TB] FAIL async_rst_busy: got %b, want 0", busy); end
        if (crcValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_rst_crc_valid: got %b, want 0", crcValid); end
        #10 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_frames();
        logic [7:0] model = 8'h00;
        logic [8:0] p = 9'h107;
        logic [7:0] d;
        int nWords;
        int lat;
        for (int f = 0; f < 30; f++) begin
            if (f == 0 || $urandom_range(0, 3) != 0) begin
                p     = {1'b1, 8'($urandom)};
                model = 8'($urandom);
                doStart(p, model);
            end
            nWords = $urandom_range(1, 5);
            for (int w = 0; w < nWords; w++) begin
                repeat ($urandom_range(0, 2)) begin
                    data = 8'($urandom);
                    @(posedge clk); #1;
                end
                d = 8'($urandom);
                sendWord(d, (w == nWords - 1));
                model = crcByte(model, p, d);
            end
            waitCrcValid(lat);
            nCompared += 2;
            if (lat != 3)      begin nMismatched++; $display("[TB] FAIL rand_latency[%0d]: got %0d, want 3", f, lat); end
            if (crc !== model) begin nMismatched++; $display("[TB] FAIL rand_crc[%0d]: got %h, want %h", f, crc, model); end
            @(posedge clk); #1;
        end
    endtask

`ifdef SPI_CRC_CHECK_EN
    task automatic test_crc_check();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            doStart(9'h107, 8'h00);
            refCrc = (pass == 0) ? 8'hF4 : 8'hF5;
            for (int i = 0; i < 9; i++) sendWord(8'h31 + 8'(i), (i == 8));
            refCrc = 8'h00;
            waitCrcValid(lat);
            nCompared += 2;
            if (lat != 3) begin nMismatched++; $display("[TB] FAIL check_latency[%0d]: got %0d, want 3", pass, lat); end
            if (crcErr !== (pass == 1)) begin
                nMismatched++;
                $display("[TB] FAIL check_crc_err[%0d]: got %b, want %b", pass, crcErr, (pass == 1));
            end
            @(posedge clk); #1;
        end
        doStart(9'h107, 8'h00);
        @(negedge clk);
        nCompared++;
        if (crcErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL check_err_cleared: got %b, want 0", crcErr); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        poly  = 9'h107;
        init  = 8'h00;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        last  = 1'b0;
`ifdef SPI_CRC_CHECK_EN
        refCrc = 8'h00;
`endif
        test_reset();
        test_single_words();
        test_back_to_back();
        test_start_abort();
        test_async_reset();
        test_random_frames();
`ifdef SPI_CRC_CHECK_EN
        test_crc_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/spi_crc_accum.md
Name: spi_crc_accum

Overview:
Sequential CRC accumulator for the SPI execution unit.
- Accepts a byte stream from the SPI shift/receive stage through a valid/ready handshake.
- Folds each byte into a running CRC register one nibble per clock, MSB-first, high nibble first.
- On the last byte, presents the final CRC with a one-cycle valid pulse to the frame checker/transmitter downstream.

Parameters:
- WPOLY, 9, polynomial width including the implicit leading 1; CRC width is WPOLY-1 and must be >= 4.
- WDATA, 8, input word width; must be a multiple of 4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_poly  in  WPOLY  generator polynomial; bit WPOLY-1 is 1; held stable during a frame.
- i_init  in  WPOLY-1  CRC seed loaded on i_start.
- i_start  in  1  frame start: loads seed and aborts any work in progress.
- i_valid  in  1  input byte valid.
- i_data  in  WDATA  input byte.
- i_last  in  1  qualifies i_data as the last word of the frame.
- o_ready  out  1  block can accept a word this cycle.
- o_busy  out  1  word processing in progress.
- o_crc  out  WPOLY-1  running/final CRC register.
- o_crc_valid  out  1  one-cycle pulse: o_crc is the final frame CRC.

Behaviour:
- Reset values (async, i_rst=1):
  - state=IDLE, nibble counter=0, crc=0, last flag=0.
  - o_crc=0, o_crc_valid=0, o_busy=0, o_ready=1.
- Nibble step, C=WPOLY-1, nibble n: t = crc XOR (n << (C-4)); repeat 4 times: t = t[C-1] ? ((t<<1) XOR i_poly[C-1:0]) : (t<<1), truncated to C bits. Result is standard MSB-first, non-reflected CRC, no final XOR.
- States:
  - IDLE: o_ready=1, o_busy=0. On i_valid&&o_ready: capture i_data and i_last, counter=WDATA/4-1, go PROC.
  - PROC: each cycle, apply nibble step using nibble [4*counter+3 : 4*counter] and decrement counter; o_busy=1.
  - PROC, counter==0 (final nibble cycle): o_ready=1 unless the captured last flag is set.
    - Accept in that cycle: capture the next word, stay in PROC with counter reloaded (back-to-back, one word per WDATA/4 cycles).
    - Else, last flag clear: go IDLE.
    - Else, last flag set: go DONE.
  - DONE: o_crc_valid=1 for exactly one cycle, o_ready=0, o_busy=0; then go IDLE. o_crc holds its value until the next i_start or word.
- Latency: final CRC is valid (o_crc_valid) WDATA/4+1 cycles after the accept of the last word.
- i_start has priority over everything:
  - Next cycle: crc=i_init, state=IDLE, last flag=0, o_crc_valid=0.
  - A word presented in the same cycle as i_start is not accepted (o_ready forced 0 that cycle).
  - i_start mid-PROC discards the partial word.
- i_valid while o_ready=0: ignored, no capture; upstream must hold.
- i_data/i_last are sampled only on accept; later changes have no effect.
- A word with i_last and no preceding i_start continues from the current crc value (no implicit reseed).

Optional Feature:
- Macro: SPI_CRC_CHECK_EN.
- With the macro defined, the block adds:
  - Port i_ref_crc (in, WPOLY-1): expected CRC, sampled on the accept of the last word.
  - Port o_crc_err (out, 1): asserted in the DONE cycle when the final crc != sampled reference, otherwise 0; reset value 0; cleared by i_start.
- Without the macro, neither port exists and the block has no compare logic.

Test Plan:
- CRC-8 setup: WPOLY=9, i_poly=9'h107, i_init=0. i_start, then single word 8'h01 with i_last -> o_crc_valid pulse exactly 3 cycles after accept, o_crc=8'h07.
- Same setup, single words 8'h80 and 8'hFF (each reseeded) -> o_crc=8'h89 and 8'hF3 respectively; 8'h00 -> 8'h00.
- ASCII "123456789" back-to-back, i_valid held high, last on '9':
  - o_ready pattern 1,0,1,0,… with 9 accepts in 18 cycles.
  - Final o_crc=8'hF4; single o_crc_valid pulse.
- i_start asserted in the cycle after accepting 8'hFF (mid-PROC), i_init=8'h5A:
  - Next cycle o_crc=8'h5A, state IDLE, no o_crc_valid.
  - Subsequent word 8'h00 with i_last gives the CRC from seed 8'h5A.
- i_rst pulsed asynchronously mid-frame -> o_crc=0, o_ready=1, o_busy=0, o_crc_valid=0 immediately, without waiting for a clock edge.
- SPI_CRC_CHECK_EN, "123456789":
  - i_ref_crc=8'hF4 -> o_crc_err=0 in the DONE cycle.
  - i_ref_crc=8'hF5 -> o_crc_err=1 in the DONE cycle; o_crc_err cleared by next i_start.
